// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: RV32M funct3 codes,
// FSM states and small op-decode helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_a_signed(input op_e op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_b_signed(input op_e op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation, used both to take operand magnitudes
// and to restore the sign of the final product/quotient/remainder.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? ({W{1'b0}} - i_val) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, with sign correction on the last step and a valid/ready result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  op_e                r_op;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_result;

  op_e                w_op;
  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div0;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_special_res;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_final;

  assign w_op     = op_e'(op);
  assign w_accept = in_valid && (r_state == StIdle) && !flush;
  assign w_a_neg  = op_a_signed(w_op) && src_a[WIDTH-1];
  assign w_b_neg  = op_b_signed(w_op) && src_b[WIDTH-1];
  assign w_div0   = op_is_div(w_op) && (src_b == '0);
  assign w_ovf    = ((w_op == OpDiv) || (w_op == OpRem)) &&
                    (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);

  muldiv_signfix #(.W(WIDTH)) u_mag_a (
    .i_val (src_a),
    .i_neg (w_a_neg),
    .o_val (w_a_mag)
  );

  muldiv_signfix #(.W(WIDTH)) u_mag_b (
    .i_val (src_b),
    .i_neg (w_b_neg),
    .o_val (w_b_mag)
  );

  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = op_is_rem(w_op) ? src_a : '1;
    end else begin
      w_special_res = op_is_rem(w_op) ? '0 : src_a;
    end
  end

  // Multiply: shift-add with multiplier in r_lo. Divide: restoring, dividend
  // shifts out of r_lo into the partial remainder r_hi; r_hi < divisor always,
  // so the borrow bit of w_diff alone decides the quotient bit.
  assign w_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opnd}) : {1'b0, r_hi};
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opnd};
  assign w_ge    = ~w_diff[WIDTH];

  always_comb begin
    w_step_hi = w_sum[WIDTH:1];
    w_step_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    if (op_is_div(r_op)) begin
      w_step_hi = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .i_val ({w_step_hi, w_step_lo}),
    .i_neg (r_neg_res),
    .o_val (w_prod_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .i_val (w_step_lo),
    .i_neg (r_neg_res),
    .o_val (w_quo_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .i_val (w_step_hi),
    .i_neg (r_neg_rem),
    .o_val (w_rem_fix)
  );

  always_comb begin
    w_final = '0;
    unique case (r_op)
      OpMul:                     w_final = w_prod_fix[WIDTH-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
      OpDiv, OpDivu:             w_final = w_quo_fix;
      OpRem, OpRemu:             w_final = w_rem_fix;
      default:                   w_final = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_nxt = (w_div0 || w_ovf) ? StDone : StCalc;
      StCalc: if (r_cnt == '0) w_state_nxt = StDone;
      StDone: if (out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (flush) w_state_nxt = StIdle;
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
    result = out_valid ? r_result : '0;
    zero   = (result == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_op      <= OpMul;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op      <= w_op;
        r_neg_res <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_cnt     <= CW'(WIDTH - 1);
        r_opnd    <= op_is_div(w_op) ? w_b_mag : w_a_mag;
        r_lo      <= op_is_div(w_op) ? w_a_mag : w_b_mag;
        r_hi      <= '0;
        r_result  <= w_special_res;
      end else if (r_state == StCalc) begin
        r_hi <= w_step_hi;
        r_lo <= w_step_lo;
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CW'(1);
        end else begin
          r_result <= w_final;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit (WIDTH=32) against a plain
// integer-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    int ia, ib;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    ua  = {32'd0, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (o[2] && (b == 0)) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".result"}, result, 32'd0);
    check({tag, ".zero"}, 32'(zero), 32'd1);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    int cyc;
    exp = ref_model(o, a, b);
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    issue(o, a, b);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, ".lat"}, 32'(cyc), 32'(ref_latency(o, a, b)));
    check({tag, ".res"}, result, exp);
    check({tag, ".zero"}, 32'(zero), 32'(exp == 0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle"}, 32'(in_ready), 32'd1);
    check({tag, ".res0"}, result, 32'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, exp;
    int sel;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; src_a = '0; src_b = '0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Directed vectors
    run_op("mul_7xm3",     3'd0, 32'd7,          32'hFFFF_FFFD);
    run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000);
    run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("mulhsu_m1x2",  3'd2, 32'hFFFF_FFFF,  32'd2);
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2);
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2);
    run_op("divu_big_2",   3'd5, 32'hFFFF_FFF9,  32'd2);
    run_op("divu_by0",     3'd5, 32'd5,          32'd0);
    run_op("remu_by0",     3'd7, 32'd5,          32'd0);
    run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF);

    // Back-pressure: result held while out_ready is low
    exp = ref_model(3'd0, 32'd123, 32'd456);
    issue(3'd0, 32'd123, 32'd456);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      check("hold.valid", 32'(out_valid), 32'd1);
      check("hold.res", result, exp);
      check("hold.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold.release", 32'(in_ready), 32'd1);

    // Flush in cycle 10 of a DIV
    issue(3'd4, 32'd1000, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.idle", 32'(in_ready), 32'd1);
    check("flush.busy", 32'(busy), 32'd0);
    sel = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) sel++;
      tick();
    end
    check("flush.no_valid", 32'(sel), 32'd0);
    run_op("mul_3x4", 3'd0, 32'd3, 32'd4);

    // Flush beats a simultaneous request
    op = 3'd0; src_a = 32'd9; src_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept.busy", 32'(busy), 32'd0);

    // Reset mid-CALC, with a flush and out_ready also asserted
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    check_reset_outputs("rst_calc");

    // Randomized operations with a bias toward divide corner cases
    for (int n = 0; n < 40; n++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) ra = 32'($urandom_range(0, 3));
      run_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits; legal values are even integers >= 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port flush, input, 1 bit: abort any operation in flight.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operation request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the unit can accept a request.
REQ-007 The block SHALL have port op, input, 3 bits: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-008 The block SHALL have ports src_a and src_b, input, WIDTH bits each: src_a is the multiplicand/dividend, src_b the multiplier/divisor.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: the operation result.
REQ-012 The block SHALL have port zero, output, 1 bit: high when result equals 0.
REQ-013 The block SHALL have port busy, output, 1 bit: high when the unit is not IDLE.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-015 in_ready SHALL be high exactly in IDLE; a request is accepted when in_valid && in_ready && !flush, which latches op, src_a and src_b.
REQ-016 On a normal accept, the block SHALL enter CALC with the iteration counter at WIDTH-1 and perform one radix-2 step per cycle on operand magnitudes.
REQ-017 After the step with counter 0, the block SHALL apply sign correction and enter DONE, so that a request accepted in cycle 0 first shows out_valid in cycle WIDTH+1.
REQ-018 MUL SHALL return the low WIDTH bits of the product; MULH the high WIDTH bits of signed x signed; MULHSU the high bits of signed src_a x unsigned src_b; MULHU the high bits of unsigned x unsigned; the full product is 2*WIDTH bits.
REQ-019 DIV/REM SHALL round toward zero, with the remainder taking the sign of the dividend; DIVU/REMU are unsigned.
REQ-020 For a divisor of 0, the block SHALL go directly from IDLE to DONE, with out_valid in cycle 1: quotient all ones and remainder src_a.
REQ-021 For signed overflow (DIV/REM with src_a = most-negative and src_b = all ones), the block SHALL go directly from IDLE to DONE, with out_valid in cycle 1: quotient src_a and remainder 0.
REQ-022 In DONE, out_valid SHALL be high and result/zero SHALL be held stable until out_ready is high, at which point the state returns to IDLE on that edge.
REQ-023 A new request SHALL NOT be accepted in the same cycle as the result handshake; the earliest next accept is the following cycle.
REQ-024 flush in any state SHALL return the unit to IDLE on the next edge, discarding the result; flush wins over a simultaneous accept or out_ready.
REQ-025 result SHALL be 0 whenever out_valid is low.

Reset
REQ-026 While rst is high at a clock edge, the state SHALL become IDLE, counter 0, and in_ready=1, out_valid=0, busy=0, result=0, zero=1.
REQ-027 Reset mid-CALC or in DONE SHALL discard the operation, and rst SHALL take priority over flush and all handshakes.

Structure
REQ-028 A shared package (muldiv_pkg) SHALL hold the op funct3 enum and the state enum.
REQ-029 The sign-correction/negation logic MAY be a sub-module muldiv_signfix; the datapath is otherwise flat.

Verification (WIDTH=32)
REQ-030 MUL 7 x 0xFFFFFFFD accepted in cycle 0 -> out_valid first in cycle 33, result 0xFFFFFFEB, zero=0.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-033 DIVU 5/0 -> out_valid in cycle 1, 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM -> 0 with zero=1, both in cycle 1.
REQ-034 Hold out_ready low for 10 cycles in DONE -> out_valid and result remain stable and in_ready stays 0; raise out_ready -> IDLE next cycle.
REQ-035 Assert flush in cycle 10 of a DIV -> IDLE in cycle 11 with no out_valid; a following MUL 3 x 4 completes normally with result 12; assert rst mid-CALC -> all outputs take their reset values.
